// File: rtl/serial_compare.sv
// rtl/serial_compare.sv - multi-cycle MSB-first magnitude comparator with early exit
module serial_compare #(
    parameter int BUS_SIZE = 16,
    parameter int DIGIT    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                signed_mode,
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    output logic                busy,
    output logic                done,
    output logic                eq,
    output logic                lt,
    output logic                gt
);
    localparam int NDIG  = BUS_SIZE / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
    localparam logic [BUS_SIZE-1:0] MSB_MASK = {1'b1, {(BUS_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BUS_SIZE-1:0] r_a;
    logic [BUS_SIZE-1:0] r_b;
    logic [IDX_W-1:0]    r_idx;
    logic                r_eq;
    logic                r_lt;
    logic                r_gt;

    logic                w_accept;
    logic [BUS_SIZE-1:0] w_sh_a;
    logic [BUS_SIZE-1:0] w_sh_b;
    logic [DIGIT-1:0]    w_dig_a;
    logic [DIGIT-1:0]    w_dig_b;
    logic                w_differ;
    logic                w_last;

    // DONE accepts start just like IDLE, giving back-to-back compares.
    assign w_accept = start && (r_state != S_SCAN);
    assign w_sh_a   = r_a >> (DIGIT * int'(r_idx));
    assign w_sh_b   = r_b >> (DIGIT * int'(r_idx));
    assign w_dig_a  = w_sh_a[DIGIT-1:0];
    assign w_dig_b  = w_sh_b[DIGIT-1:0];
    assign w_differ = (w_dig_a != w_dig_b);
    assign w_last   = (r_idx == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_SCAN : S_IDLE;
            S_SCAN:  w_next = (w_differ || w_last) ? S_DONE : S_SCAN;
            S_DONE:  w_next = w_accept ? S_SCAN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_SCAN);
        done = (r_state == S_DONE);
        eq   = r_eq;
        lt   = r_lt;
        gt   = r_gt;
    end

    // Flipping both MSBs maps two's complement onto offset binary, so the
    // unsigned digit scan below serves both modes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= signed_mode ? (a ^ MSB_MASK) : a;
            r_b   <= signed_mode ? (b ^ MSB_MASK) : b;
            r_idx <= LAST_IDX;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
        end else if (r_state == S_SCAN) begin
            if (w_differ) begin
                r_lt <= (w_dig_a < w_dig_b);
                r_gt <= (w_dig_a > w_dig_b);
            end else if (w_last) begin
                r_eq <= 1'b1;
            end else begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end
endmodule
